// File: rtl/vend_txn_ctrl_if.sv
// Vending transaction controller bus: coin/selection inputs, status outputs,
// and the dispenser / change-hopper request-acknowledge pairs.
interface vend_txn_ctrl_if;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       sel_left;
    logic       sel_right;
    logic       buy;
    logic       cancel;
    logic       disp_ack;
    logic       chg_ack;

    logic [6:0] credit;
    logic [2:0] item_idx;
    logic [3:0] item_price;
    logic [4:0] afford;
    logic       disp_req;
    logic [2:0] disp_item;
    logic       chg_req;
    logic [1:0] chg_coin;
    logic       coin_reject;
    logic       busy;

    // Driver side (front panel, coin mech, dispenser, hopper)
    modport master (
        output coin_valid, coin_sel, sel_left, sel_right, buy, cancel, disp_ack, chg_ack,
        input  credit, item_idx, item_price, afford, disp_req, disp_item,
               chg_req, chg_coin, coin_reject, busy
    );

    // Controller side
    modport slave (
        input  coin_valid, coin_sel, sel_left, sel_right, buy, cancel, disp_ack, chg_ack,
        output credit, item_idx, item_price, afford, disp_req, disp_item,
               chg_req, chg_coin, coin_reject, busy
    );
endinterface

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: accumulates coin credit, lets the user
// scroll through five items, dispenses a purchase and pays change back one
// coin at a time (largest denomination first) with a one-cycle gap between coins.
module vend_txn_ctrl #(
    parameter logic [3:0] PRICE0     = 4'd7,
    parameter logic [3:0] PRICE1     = 4'd5,
    parameter logic [3:0] PRICE2     = 4'd6,
    parameter logic [3:0] PRICE3     = 4'd10,
    parameter logic [3:0] PRICE4     = 4'd8,
    parameter logic [6:0] MAX_CREDIT = 7'd79
) (
    input  logic           clk,
    input  logic           rst,
    vend_txn_ctrl_if.slave bus
);
    localparam logic [3:0] PRICE_TBL [5] = '{PRICE0, PRICE1, PRICE2, PRICE3, PRICE4};

    typedef enum logic [1:0] {
        ACCEPT   = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2,
        CHG_GAP  = 2'd3
    } state_t;

    state_t     state_reg;
    logic [6:0] credit_reg;
    logic [2:0] item_idx_reg;
    logic [2:0] disp_item_reg;
    logic [1:0] chg_coin_reg;
    logic       disp_req_reg;
    logic       chg_req_reg;
    logic       coin_reject_reg;

    logic [3:0] item_price;
    logic [7:0] coin_sum;
    logic [1:0] change_code;

    // Coin code to value: 0=1, 1=5, 2=10, 3=20
    function automatic logic [6:0] coin_value(input logic [1:0] code);
        case (code)
            2'd0:    coin_value = 7'd1;
            2'd1:    coin_value = 7'd5;
            2'd2:    coin_value = 7'd10;
            default: coin_value = 7'd20;
        endcase
    endfunction

    // Largest denomination not exceeding the given credit
    function automatic logic [1:0] largest_coin(input logic [6:0] amount);
        if (amount >= 7'd20)      largest_coin = 2'd3;
        else if (amount >= 7'd10) largest_coin = 2'd2;
        else if (amount >= 7'd5)  largest_coin = 2'd1;
        else                      largest_coin = 2'd0;
    endfunction

    // Price lookup for the currently selected item
    always_comb begin
        item_price = PRICE0;
        case (item_idx_reg)
            3'd0:    item_price = PRICE0;
            3'd1:    item_price = PRICE1;
            3'd2:    item_price = PRICE2;
            3'd3:    item_price = PRICE3;
            3'd4:    item_price = PRICE4;
            default: item_price = PRICE0;
        endcase
    end

    // One extra bit so an over-ceiling sum can never wrap into an accepted value
    assign coin_sum    = {1'b0, credit_reg} + {1'b0, coin_value(bus.coin_sel)};
    // Credit is stable on every transition into CHANGE, so the current value names the coin
    assign change_code = largest_coin(credit_reg);

    // Transaction FSM with all handshake outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ACCEPT;
            credit_reg      <= '0;
            item_idx_reg    <= '0;
            disp_item_reg   <= '0;
            chg_coin_reg    <= '0;
            disp_req_reg    <= 1'b0;
            chg_req_reg     <= 1'b0;
            coin_reject_reg <= 1'b0;
        end else begin
            coin_reject_reg <= 1'b0;
            case (state_reg)
                ACCEPT: begin
                    if (bus.cancel) begin
                        // A coin arriving alongside a higher-priority event is refused
                        coin_reject_reg <= bus.coin_valid;
                        if (credit_reg != '0) begin
                            state_reg    <= CHANGE;
                            chg_req_reg  <= 1'b1;
                            chg_coin_reg <= change_code;
                        end
                    end else if (bus.buy) begin
                        coin_reject_reg <= bus.coin_valid;
                        if (credit_reg >= {3'b000, item_price}) begin
                            credit_reg    <= credit_reg - {3'b000, item_price};
                            disp_item_reg <= item_idx_reg;
                            state_reg     <= DISPENSE;
                            disp_req_reg  <= 1'b1;
                        end
                    end else if (bus.coin_valid) begin
                        if (coin_sum <= {1'b0, MAX_CREDIT})
                            credit_reg <= coin_sum[6:0];
                        else
                            coin_reject_reg <= 1'b1;
                    end else if (bus.sel_right && !bus.sel_left) begin
                        item_idx_reg <= (item_idx_reg == 3'd4) ? 3'd0 : item_idx_reg + 3'd1;
                    end else if (bus.sel_left && !bus.sel_right) begin
                        item_idx_reg <= (item_idx_reg == 3'd0) ? 3'd4 : item_idx_reg - 3'd1;
                    end
                end
                DISPENSE: begin
                    coin_reject_reg <= bus.coin_valid;
                    if (bus.disp_ack) begin
                        disp_req_reg <= 1'b0;
                        if (credit_reg != '0) begin
                            state_reg    <= CHANGE;
                            chg_req_reg  <= 1'b1;
                            chg_coin_reg <= change_code;
                        end else begin
                            state_reg <= ACCEPT;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject_reg <= bus.coin_valid;
                    if (bus.chg_ack) begin
                        // chg_coin never exceeds credit, so this cannot underflow
                        credit_reg  <= credit_reg - coin_value(chg_coin_reg);
                        chg_req_reg <= 1'b0;
                        state_reg   <= CHG_GAP;
                    end
                end
                CHG_GAP: begin
                    coin_reject_reg <= bus.coin_valid;
                    if (credit_reg != '0) begin
                        state_reg    <= CHANGE;
                        chg_req_reg  <= 1'b1;
                        chg_coin_reg <= change_code;
                    end else begin
                        state_reg <= ACCEPT;
                    end
                end
                default: begin
                    state_reg <= ACCEPT;
                end
            endcase
        end
    end

    // One affordability flag per item price
    for (genvar gi = 0; gi < 5; gi++) begin : g_afford
        assign bus.afford[gi] = (credit_reg >= {3'b000, PRICE_TBL[gi]});
    end

    assign bus.credit      = credit_reg;
    assign bus.item_idx    = item_idx_reg;
    assign bus.item_price  = item_price;
    assign bus.disp_req    = disp_req_reg;
    assign bus.disp_item   = disp_item_reg;
    assign bus.chg_req     = chg_req_reg;
    assign bus.chg_coin    = chg_coin_reg;
    assign bus.coin_reject = coin_reject_reg;
    assign bus.busy        = (state_reg != ACCEPT);
endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Bench for vend_txn_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the vending rules.
module tb_vend_txn_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_txn_ctrl_if bus();
    vend_txn_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int PRICES [5] = '{7, 5, 6, 10, 8};
    localparam int COINS  [4] = '{1, 5, 10, 20};
    localparam int CEILING    = 79;

    // Model phases: idle/vending/paying a coin/pause between coins
    localparam int PH_IDLE   = 0;
    localparam int PH_VEND   = 1;
    localparam int PH_PAYOUT = 2;
    localparam int PH_PAUSE  = 3;

    int vectors    = 0;
    int miscompares = 0;

    int m_credit    = 0;
    int m_item      = 0;
    int m_disp_item = 0;
    int m_phase     = PH_IDLE;
    bit m_reject    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int best_coin(input int c);
        for (int k = 3; k >= 0; k--)
            if (COINS[k] <= c) return k;
        return 0;
    endfunction

    function automatic logic [31:0] exp_afford(input int c);
        logic [31:0] a = '0;
        for (int i = 0; i < 5; i++) a[i] = (c >= PRICES[i]);
        return a;
    endfunction

    // Apply the vending rules to the inputs held across the last clock edge
    task automatic model_step();
        if (rst) begin
            m_credit = 0; m_item = 0; m_disp_item = 0; m_phase = PH_IDLE; m_reject = 1'b0;
            return;
        end
        m_reject = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (bus.cancel) begin
                    m_reject = bus.coin_valid;
                    if (m_credit > 0) m_phase = PH_PAYOUT;
                end else if (bus.buy) begin
                    m_reject = bus.coin_valid;
                    if (m_credit >= PRICES[m_item]) begin
                        m_credit   -= PRICES[m_item];
                        m_disp_item = m_item;
                        m_phase     = PH_VEND;
                    end
                end else if (bus.coin_valid) begin
                    if (m_credit + COINS[bus.coin_sel] <= CEILING) m_credit += COINS[bus.coin_sel];
                    else m_reject = 1'b1;
                end else if (bus.sel_right && !bus.sel_left) begin
                    m_item = (m_item + 1) % 5;
                end else if (bus.sel_left && !bus.sel_right) begin
                    m_item = (m_item + 4) % 5;
                end
            end
            PH_VEND: begin
                m_reject = bus.coin_valid;
                if (bus.disp_ack) m_phase = (m_credit > 0) ? PH_PAYOUT : PH_IDLE;
            end
            PH_PAYOUT: begin
                m_reject = bus.coin_valid;
                if (bus.chg_ack) begin
                    m_credit -= COINS[best_coin(m_credit)];
                    m_phase   = PH_PAUSE;
                end
            end
            default: begin
                m_reject = bus.coin_valid;
                m_phase  = (m_credit > 0) ? PH_PAYOUT : PH_IDLE;
            end
        endcase
    endtask

    task automatic check_all();
        chk("credit",      32'(bus.credit),      m_credit);
        chk("item_idx",    32'(bus.item_idx),    m_item);
        chk("item_price",  32'(bus.item_price),  PRICES[m_item]);
        chk("afford",      32'(bus.afford),      exp_afford(m_credit));
        chk("busy",        32'(bus.busy),        32'(m_phase != PH_IDLE));
        chk("disp_req",    32'(bus.disp_req),    32'(m_phase == PH_VEND));
        chk("chg_req",     32'(bus.chg_req),     32'(m_phase == PH_PAYOUT));
        chk("coin_reject", 32'(bus.coin_reject), 32'(m_reject));
        if (m_phase == PH_VEND)   chk("disp_item", 32'(bus.disp_item), m_disp_item);
        if (m_phase == PH_PAYOUT) chk("chg_coin",  32'(bus.chg_coin),  best_coin(m_credit));
    endtask

    // One clock: inputs set beforehand are held over the edge, then released
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check_all();
        bus.coin_valid = 1'b0; bus.coin_sel = 2'd0;
        bus.sel_left = 1'b0; bus.sel_right = 1'b0; bus.buy = 1'b0; bus.cancel = 1'b0;
        bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;
        rst = 1'b0;
    endtask

    task automatic coin(input logic [1:0] code);
        bus.coin_valid = 1'b1;
        bus.coin_sel   = code;
        cycle();
    endtask

    // Acknowledge everything until the transaction completes, within a cycle budget
    task automatic drain();
        for (int k = 0; k < 60 && m_phase != PH_IDLE; k++) begin
            bus.disp_ack = 1'b1;
            bus.chg_ack  = 1'b1;
            cycle();
        end
        chk("drain_idle", 32'(bus.busy), 32'd0);
    endtask

    // Hard time limit in case the clocking itself stalls
    initial begin
        #2ms;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0] chg_seq [5];
        chg_seq = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};

        bus.coin_valid = 1'b0; bus.coin_sel = 2'd0;
        bus.sel_left = 1'b0; bus.sel_right = 1'b0; bus.buy = 1'b0; bus.cancel = 1'b0;
        bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;
        rst = 1'b1;
        cycle();
        chk("rst_credit", 32'(bus.credit), 32'd0);
        chk("rst_afford", 32'(bus.afford), 32'd0);
        chk("rst_price",  32'(bus.item_price), 32'd7);
        cycle();

        // Coins 20, 5, 1
        coin(2'd3); coin(2'd1); coin(2'd0);
        chk("s1_credit", 32'(bus.credit), 32'd26);
        chk("s1_afford", 32'(bus.afford), 32'b11111);

        // Scroll left to item 4, buy, dispense, pay change 10,5,1,1,1
        bus.sel_left = 1'b1; cycle();
        chk("s2_item", 32'(bus.item_idx), 32'd4);
        chk("s2_price", 32'(bus.item_price), 32'd8);
        bus.buy = 1'b1; cycle();
        chk("s2_credit", 32'(bus.credit), 32'd18);
        chk("s2_disp_req", 32'(bus.disp_req), 32'd1);
        chk("s2_disp_item", 32'(bus.disp_item), 32'd4);
        cycle(); cycle();
        bus.disp_ack = 1'b1; cycle();
        chk("s2_chg_req", 32'(bus.chg_req), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("s2_chg_coin", 32'(bus.chg_coin), 32'(chg_seq[k]));
            bus.chg_ack = 1'b1; cycle();
            chk("s2_gap", 32'(bus.chg_req), 32'd0);
            cycle();
        end
        chk("s2_end_credit", 32'(bus.credit), 32'd0);
        chk("s2_end_busy", 32'(bus.busy), 32'd0);

        // Ceiling: 70 + 20 refused, then 70 + 5 accepted
        coin(2'd3); coin(2'd3); coin(2'd3); coin(2'd2);
        chk("s3_credit70", 32'(bus.credit), 32'd70);
        coin(2'd3);
        chk("s3_hold70", 32'(bus.credit), 32'd70);
        chk("s3_reject", 32'(bus.coin_reject), 32'd1);
        cycle();
        chk("s3_reject_end", 32'(bus.coin_reject), 32'd0);
        coin(2'd1);
        chk("s3_credit75", 32'(bus.credit), 32'd75);

        // Refund all, cancel at zero, short buy at credit 4 on item 1
        bus.cancel = 1'b1; cycle();
        drain();
        bus.cancel = 1'b1; cycle();
        chk("s4_cancel0_busy", 32'(bus.busy), 32'd0);
        coin(2'd0); coin(2'd0); coin(2'd0); coin(2'd0);
        bus.sel_right = 1'b1; cycle();
        bus.sel_right = 1'b1; cycle();
        chk("s4_item1", 32'(bus.item_idx), 32'd1);
        bus.buy = 1'b1; cycle();
        chk("s4_short_busy", 32'(bus.busy), 32'd0);
        chk("s4_short_credit", 32'(bus.credit), 32'd4);

        // Buy + coin + sel_right together
        coin(2'd1);
        bus.buy = 1'b1; bus.coin_valid = 1'b1; bus.coin_sel = 2'd0; bus.sel_right = 1'b1;
        cycle();
        chk("s5_credit", 32'(bus.credit), 32'd4);
        chk("s5_disp_req", 32'(bus.disp_req), 32'd1);
        chk("s5_reject", 32'(bus.coin_reject), 32'd1);
        chk("s5_item", 32'(bus.item_idx), 32'd1);
        drain();

        // Reset in the middle of paying change
        coin(2'd2); coin(2'd0); coin(2'd0);
        bus.cancel = 1'b1; cycle();
        chk("s6_chg_req", 32'(bus.chg_req), 32'd1);
        chk("s6_credit", 32'(bus.credit), 32'd12);
        rst = 1'b1; cycle();
        chk("s6_rst_credit", 32'(bus.credit), 32'd0);
        chk("s6_rst_busy", 32'(bus.busy), 32'd0);
        chk("s6_rst_chg_req", 32'(bus.chg_req), 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bus.coin_valid = ($urandom_range(0, 3) == 0);
            bus.coin_sel   = 2'($urandom_range(0, 3));
            bus.sel_left   = ($urandom_range(0, 5) == 0);
            bus.sel_right  = ($urandom_range(0, 5) == 0);
            bus.buy        = ($urandom_range(0, 7) == 0);
            bus.cancel     = ($urandom_range(0, 15) == 0);
            bus.disp_ack   = ($urandom_range(0, 2) == 0);
            bus.chg_ack    = ($urandom_range(0, 1) == 0);
            rst            = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
